pulse_seq_ctrl: RTL and testbench

- Sequencing controller for the period-based pulse monitor datapath: debounce, single pulser, period counter, 4-deep period shift registers, average, period-to-bpm, BCD display.
- Owns the period counter's clear and enable and the shift-register enable.
- Rejects out-of-range beat intervals, tracks how many valid periods are loaded, declares signal loss on timeout, and tells the display when the average is trustworthy.

---
 rtl/pulse_pkg.sv | 20 ++
 rtl/pulse_seq_ctrl_if.sv | 28 ++
 rtl/timeout_timer.sv | 30 +++
 rtl/pulse_seq_ctrl.sv | 111 +++++++++++
 tb/tb_pulse_seq_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_pkg.sv
// Shared types and sizing for the pulse monitor datapath and its sequencing controller.
// Constants only; no logic, no latency, no flow control.
package pulse_pkg;

  localparam int PD_W           = 6;
  localparam int NSAMP          = 4;
  localparam int NSAMP_W        = 3;
  localparam int REJ_W          = 8;
  localparam int PD_MIN_DEF     = 3;
  localparam int PD_MAX_DEF     = 20;
  localparam int LOST_TICKS_DEF = 30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    LOST    = 2'd3
  } state_t;

endpackage

// File: rtl/pulse_seq_ctrl_if.sv
// Beat/timebase inputs and period-counter/display control outputs of the sequencer.
// Master is the controller; slave is the datapath side that supplies beat, tick and count.
interface pulse_seq_ctrl_if;
  import pulse_pkg::*;

  logic               beat;
  logic               tick;
  logic [PD_W-1:0]    count;
  logic               count_enb;
  logic               clr_count;
  logic               shift_enb;
  logic               avg_valid;
  logic               blank;
  logic               lost;
  logic [NSAMP_W-1:0] nsamp;
  logic [REJ_W-1:0]   rej_cnt;

  modport master (
    input  beat, tick, count,
    output count_enb, clr_count, shift_enb, avg_valid, blank, lost, nsamp, rej_cnt
  );

  modport slave (
    output beat, tick, count,
    input  count_enb, clr_count, shift_enb, avg_valid, blank, lost, nsamp, rej_cnt
  );

endinterface

// File: rtl/timeout_timer.sv
// Tick-driven saturating counter with synchronous clear; term flags the limit.
// Count updates one cycle after tick; clear has priority over tick; no backpressure.
module timeout_timer #(
  parameter int LIMIT = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic clr,
  output logic term
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM_C = CW'(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick && (cnt != LIM_C)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign term = (cnt == LIM_C);

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Sequencer for the period-based pulse monitor: beat qualification, sample loading, loss detection.
// Beat in cycle N yields clr_count/shift_enb in cycle N+1 for one cycle; no backpressure.
module pulse_seq_ctrl
  import pulse_pkg::*;
#(
  parameter int PD_MIN     = PD_MIN_DEF,
  parameter int PD_MAX     = PD_MAX_DEF,
  parameter int LOST_TICKS = LOST_TICKS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  pulse_seq_ctrl_if.master bus
);

  localparam logic [PD_W-1:0]    MIN_C = PD_W'(PD_MIN);
  localparam logic [PD_W-1:0]    MAX_C = PD_W'(PD_MAX);
  localparam logic [NSAMP_W-1:0] NS_C  = NSAMP_W'(NSAMP);
  localparam logic [REJ_W-1:0]   REJ_SAT = '1;

  state_t             state;
  logic               clr_q;
  logic               shift_q;
  logic               avg_q;
  logic               blank_q;
  logic               lost_q;
  logic [NSAMP_W-1:0] nsamp_q;
  logic [REJ_W-1:0]   rej_q;
  logic [NSAMP_W-1:0] nsamp_inc;
  logic [REJ_W-1:0]   rej_inc;
  logic               term;
  logic               timing;

  assign nsamp_inc = (nsamp_q == NS_C) ? nsamp_q : nsamp_q + NSAMP_W'(1);
  assign rej_inc   = (rej_q == REJ_SAT) ? rej_q : rej_q + REJ_W'(1);
  assign timing    = (state == ACQUIRE) || (state == TRACK);

  timeout_timer #(.LIMIT(LOST_TICKS)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (bus.tick),
    .clr  (clr_q),
    .term (term)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      clr_q   <= 1'b0;
      shift_q <= 1'b0;
      avg_q   <= 1'b0;
      blank_q <= 1'b1;
      lost_q  <= 1'b0;
      nsamp_q <= '0;
      rej_q   <= '0;
    end else begin
      clr_q   <= 1'b0;
      shift_q <= 1'b0;
      case (state)
        IDLE, LOST: begin
          if (bus.beat) begin
            clr_q   <= 1'b1;
            nsamp_q <= '0;
            state   <= ACQUIRE;
            avg_q   <= 1'b0;
            blank_q <= 1'b1;
            lost_q  <= 1'b0;
          end
        end
        ACQUIRE, TRACK: begin
          if (bus.beat) begin
            if (bus.count < MIN_C) begin
              rej_q <= rej_inc;
            end else if (bus.count <= MAX_C) begin
              shift_q <= 1'b1;
              clr_q   <= 1'b1;
              nsamp_q <= nsamp_inc;
              if (nsamp_inc == NS_C) begin
                state   <= TRACK;
                avg_q   <= 1'b1;
                blank_q <= 1'b0;
              end
            end else begin
              clr_q <= 1'b1;
              rej_q <= rej_inc;
            end
          // The timer still shows its old value while its clear is being applied.
          end else if (term && !clr_q) begin
            state   <= LOST;
            nsamp_q <= '0;
            avg_q   <= 1'b0;
            blank_q <= 1'b1;
            lost_q  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.count_enb = bus.tick && timing && !clr_q;
  assign bus.clr_count = clr_q;
  assign bus.shift_enb = shift_q;
  assign bus.avg_valid = avg_q;
  assign bus.blank     = blank_q;
  assign bus.lost      = lost_q;
  assign bus.nsamp     = nsamp_q;
  assign bus.rej_cnt   = rej_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Scoreboard bench for pulse_seq_ctrl: beats push expected pulses/counters, a negedge monitor pops them.
module tb_pulse_seq_ctrl;
  import pulse_pkg::*;

  typedef struct {
    int         cyc;
    logic       shift;
    logic       clr;
    logic [2:0] nsamp;
    logic [7:0] rej;
    logic       avg;
    logic       lost;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  state_t     m_state;
  logic [2:0] m_nsamp;
  logic [7:0] m_rej;

  pulse_seq_ctrl_if bus ();

  pulse_seq_ctrl dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_e = exp_q.pop_front();
        check_eq("shift_enb", {31'd0, bus.shift_enb}, {31'd0, mon_e.shift});
        check_eq("clr_count", {31'd0, bus.clr_count}, {31'd0, mon_e.clr});
        check_eq("nsamp", {29'd0, bus.nsamp}, {29'd0, mon_e.nsamp});
        check_eq("rej_cnt", {24'd0, bus.rej_cnt}, {24'd0, mon_e.rej});
        check_eq("avg_valid", {31'd0, bus.avg_valid}, {31'd0, mon_e.avg});
        check_eq("blank", {31'd0, bus.blank}, {31'd0, !mon_e.avg});
        check_eq("lost", {31'd0, bus.lost}, {31'd0, mon_e.lost});
      end else begin
        check_eq("spurious_pulse", {30'd0, bus.shift_enb, bus.clr_count}, 32'd0);
      end
    end
  end

  task automatic model_reset();
    m_state = IDLE;
    m_nsamp = 3'd0;
    m_rej   = 8'd0;
  endtask

  task automatic model_beat(input logic [5:0] c, output logic sh, output logic cl);
    sh = 1'b0;
    cl = 1'b0;
    if (m_state == IDLE || m_state == LOST) begin
      cl = 1'b1;
      m_state = ACQUIRE;
      m_nsamp = 3'd0;
    end else if (c < 6'd3) begin
      if (m_rej != 8'd255) m_rej = m_rej + 8'd1;
    end else if (c <= 6'd20) begin
      sh = 1'b1;
      cl = 1'b1;
      if (m_nsamp < 3'd4) m_nsamp = m_nsamp + 3'd1;
      if (m_nsamp == 3'd4) m_state = TRACK;
    end else begin
      cl = 1'b1;
      if (m_rej != 8'd255) m_rej = m_rej + 8'd1;
    end
  endtask

  task automatic beat_at(input logic [5:0] c, input logic tk);
    logic sh, cl, trk_pre, trk_post;
    exp_t e;
    @(posedge clk); #1;
    trk_pre = (m_state == ACQUIRE || m_state == TRACK);
    bus.beat  = 1'b1;
    bus.count = c;
    bus.tick  = tk;
    model_beat(c, sh, cl);
    trk_post = (m_state == ACQUIRE || m_state == TRACK);
    e.cyc = cyc + 1;  e.shift = sh;  e.clr = cl;
    e.nsamp = m_nsamp;  e.rej = m_rej;
    e.avg = (m_state == TRACK);  e.lost = (m_state == LOST);
    exp_q.push_back(e);
    @(negedge clk);
    check_eq("enb_beat_cycle", {31'd0, bus.count_enb}, {31'd0, tk & trk_pre});
    @(posedge clk); #1;
    bus.beat = 1'b0;
    @(negedge clk);
    check_eq("enb_clr_cycle", {31'd0, bus.count_enb}, {31'd0, tk & trk_post & !cl});
    bus.tick = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.tick = 1'b1;
    end
    @(posedge clk); #1;
    bus.tick = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    bus.tick = 1'b1;
    #1;
    check_eq({tag, "_count_enb"}, {31'd0, bus.count_enb}, 32'd0);
    bus.tick = 1'b0;
    check_eq({tag, "_clr"}, {31'd0, bus.clr_count}, 32'd0);
    check_eq({tag, "_shift"}, {31'd0, bus.shift_enb}, 32'd0);
    check_eq({tag, "_avg"}, {31'd0, bus.avg_valid}, 32'd0);
    check_eq({tag, "_blank"}, {31'd0, bus.blank}, 32'd1);
    check_eq({tag, "_lost"}, {31'd0, bus.lost}, 32'd0);
    check_eq({tag, "_nsamp"}, {29'd0, bus.nsamp}, 32'd0);
    check_eq({tag, "_rej"}, {24'd0, bus.rej_cnt}, 32'd0);
    check_eq({tag, "_state"}, {30'd0, dut.state}, {30'd0, IDLE});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.beat = 1'b0;
    bus.tick = 1'b0;
    bus.count = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Acquisition: timing beat, then four accepted periods reach TRACK.
    beat_at(6'd10, 1'b1);
    for (int i = 0; i < 4; i++) beat_at(6'd10, 1'b1);

    // Artifact, then an accepted beat with the counter still running.
    beat_at(6'd2, 1'b0);
    beat_at(6'd9, 1'b1);

    // Resync above range, then both range edges.
    beat_at(6'd21, 1'b0);
    beat_at(6'd3, 1'b1);
    beat_at(6'd20, 1'b1);

    // Timeout in TRACK.
    @(posedge clk); #1;
    bus.tick = 1'b1;
    @(negedge clk);
    check_eq("enb_track_tick", {31'd0, bus.count_enb}, 32'd1);
    tick_n(29);
    @(negedge clk);
    check_eq("lost_not_yet", {31'd0, bus.lost}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("lost_flag", {31'd0, bus.lost}, 32'd1);
    check_eq("lost_avg", {31'd0, bus.avg_valid}, 32'd0);
    check_eq("lost_blank", {31'd0, bus.blank}, 32'd1);
    check_eq("lost_nsamp", {29'd0, bus.nsamp}, 32'd0);
    bus.tick = 1'b1;
    #1;
    check_eq("lost_count_enb", {31'd0, bus.count_enb}, 32'd0);
    bus.tick = 1'b0;
    m_state = LOST;
    m_nsamp = 3'd0;

    // Recover and refill.
    beat_at(6'd10, 1'b0);
    for (int i = 0; i < 4; i++) beat_at(6'd10, 1'b0);

    // Beat coincident with the terminal tick wins; timer restarts.
    tick_n(29);
    beat_at(6'd10, 1'b1);
    repeat (2) @(negedge clk);
    check_eq("coinc_no_lost", {31'd0, bus.lost}, 32'd0);
    check_eq("coinc_avg", {31'd0, bus.avg_valid}, 32'd1);
    tick_n(29);
    @(negedge clk);
    check_eq("timer_cleared", {31'd0, bus.lost}, 32'd0);

    // Drive rej_cnt into saturation.
    for (int i = 0; i < 260; i++) beat_at(6'd1, 1'b0);
    check_eq("rej_saturated", {24'd0, bus.rej_cnt}, 32'd255);

    // Reset while an accepted beat's pulse is pending.
    @(posedge clk); #1;
    bus.beat = 1'b1;
    bus.count = 6'd10;
    #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    bus.beat = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
